// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad operand entry block.
// Key codes, FSM state encoding and special keypad positions live here so the
// decoder and the entry controller agree on a single definition.
package keypad_pkg;

  // Key codes after decoding a {col,row} position; digit codes equal their value.
  typedef enum logic [3:0] {
    KEY_0    = 4'd0,
    KEY_1    = 4'd1,
    KEY_2    = 4'd2,
    KEY_3    = 4'd3,
    KEY_4    = 4'd4,
    KEY_5    = 4'd5,
    KEY_6    = 4'd6,
    KEY_7    = 4'd7,
    KEY_8    = 4'd8,
    KEY_9    = 4'd9,
    KEY_CLR  = 4'd10,
    KEY_ENT  = 4'd11,
    KEY_BSP  = 4'd12,
    KEY_NONE = 4'd13
  } key_code_t;

  // Operand entry controller states.
  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } entry_state_t;

  // Keypad positions ({col,row}) of the function keys.
  localparam logic [3:0] POS_CLR = 4'd3;
  localparam logic [3:0] POS_ENT = 4'd11;
  localparam logic [3:0] POS_BSP = 4'd15;

  // True when the key code carries a decimal digit.
  function automatic logic is_digit(input key_code_t code);
    return (4'(code) <= 4'd9);
  endfunction

  // Digit value carried by a digit key code.
  function automatic logic [3:0] key_digit(input key_code_t code);
    return 4'(code);
  endfunction

endpackage

// File: rtl/keypad_key_map.sv
// Combinational decoder from keypad position {col,row} to a key code.
// Positions 12..14 (A/B/C) carry no function and decode to KEY_NONE.
module keypad_key_map
  import keypad_pkg::*;
(
  input  logic [3:0] pos,
  output key_code_t  key_code
);

  // Fixed keypad legend lookup.
  always_comb begin
    key_code = KEY_NONE;
    case (pos)
      4'd0:    key_code = KEY_1;
      4'd1:    key_code = KEY_4;
      4'd2:    key_code = KEY_7;
      4'd4:    key_code = KEY_2;
      4'd5:    key_code = KEY_5;
      4'd6:    key_code = KEY_8;
      4'd7:    key_code = KEY_0;
      4'd8:    key_code = KEY_3;
      4'd9:    key_code = KEY_6;
      4'd10:   key_code = KEY_9;
      POS_CLR: key_code = KEY_CLR;
      POS_ENT: key_code = KEY_ENT;
      POS_BSP: key_code = KEY_BSP;
      default: key_code = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Multi-digit decimal operand entry for the multiplier front end.
// Keypad events shift digits into a BCD register; ENT starts a sequential
// MSD-first BCD to binary conversion (one digit per cycle) and the result is
// offered on a valid/ack handshake. Backspace support is compiled in with the
// KEYPAD_BACKSPACE_EN macro; without it the D key is rejected like A/B/C.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter  int NUM_DIGITS = 2,
  localparam int BIN_W      = $clog2(10 ** NUM_DIGITS),
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1),
  localparam int BCD_W      = 4 * NUM_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid_i,
  input  logic [1:0]       key_col_i,
  input  logic [1:0]       key_row_i,
  input  logic             op_ack_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic [CNT_W-1:0] digit_cnt_o,
  output logic [BIN_W-1:0] bin_o,
  output logic             op_valid_o,
  output logic             key_reject_o
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIN_W-1:0] BIN_TEN  = BIN_W'(4'd10);

  entry_state_t     state_r;
  logic [BCD_W-1:0] bcd_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] idx_r;
  logic [BIN_W-1:0] bin_r;
  logic             op_valid_r;
  logic             key_reject_r;
  logic             key_prev_r;

  logic             key_event_s;
  key_code_t        key_code_s;
  logic [CNT_W-1:0] digit_pos_s;
  logic [3:0]       conv_digit_s;
  logic [BIN_W-1:0] acc_next_s;

  keypad_key_map u_key_map (
    .pos      ({key_col_i, key_row_i}),
    .key_code (key_code_s)
  );

  // Rising edge of the debounced key level marks exactly one event per press.
  always_comb begin
    key_event_s = key_valid_i & ~key_prev_r;
  end

  // Select the BCD digit consumed at this conversion step, MSD first.
  always_comb begin
    digit_pos_s  = IDX_LAST - idx_r;
    conv_digit_s = 4'(bcd_r >> {digit_pos_s, 2'b00});
    acc_next_s   = (bin_r * BIN_TEN) + BIN_W'(conv_digit_s);
  end

  // Entry / conversion / handshake controller with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ENTRY;
      bcd_r        <= '0;
      cnt_r        <= '0;
      idx_r        <= '0;
      bin_r        <= '0;
      op_valid_r   <= 1'b0;
      key_reject_r <= 1'b0;
      key_prev_r   <= 1'b0;
    end else begin
      key_prev_r   <= key_valid_i;
      key_reject_r <= 1'b0;
      case (state_r)
        ENTRY: begin
          if (key_event_s) begin
            case (key_code_s)
              KEY_CLR: begin
                bcd_r <= '0;
                cnt_r <= '0;
              end
              KEY_ENT: begin
                if (cnt_r == '0) begin
                  key_reject_r <= 1'b1;
                end else begin
                  bin_r   <= '0;
                  idx_r   <= '0;
                  state_r <= CONVERT;
                end
              end
              KEY_BSP: begin
`ifdef KEYPAD_BACKSPACE_EN
                if (cnt_r == '0) begin
                  key_reject_r <= 1'b1;
                end else begin
                  bcd_r <= bcd_r >> 4'd4;
                  cnt_r <= cnt_r - CNT_ONE;
                end
`else
                key_reject_r <= 1'b1;
`endif
              end
              KEY_NONE: begin
                key_reject_r <= 1'b1;
              end
              default: begin
                // Remaining codes are the ten digits.
                if (is_digit(key_code_s) && (cnt_r < CNT_FULL)) begin
                  bcd_r <= (bcd_r << 4'd4) | BCD_W'(key_digit(key_code_s));
                  cnt_r <= cnt_r + CNT_ONE;
                end else begin
                  key_reject_r <= 1'b1;
                end
              end
            endcase
          end
        end
        CONVERT: begin
          key_reject_r <= key_event_s;
          bin_r        <= acc_next_s;
          idx_r        <= idx_r + CNT_ONE;
          if (idx_r == IDX_LAST) begin
            state_r    <= DONE;
            op_valid_r <= 1'b1;
          end
        end
        DONE: begin
          key_reject_r <= key_event_s;
          if (op_ack_i) begin
            op_valid_r <= 1'b0;
            bcd_r      <= '0;
            cnt_r      <= '0;
            state_r    <= ENTRY;
          end
        end
        default: begin
          state_r    <= ENTRY;
          op_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_o        = bcd_r;
  assign digit_cnt_o  = cnt_r;
  assign bin_o        = bin_r;
  assign op_valid_o   = op_valid_r;
  assign key_reject_o = key_reject_r;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Self-checking bench for keypad_operand_entry: directed test-plan scenarios
// followed by randomized keypad traffic, all compared every cycle against a
// digit-list reference model of the operand entry rules.
module tb_keypad_operand_entry;

  localparam int N     = 2;
  localparam int BIN_W = $clog2(10 ** N);
  localparam int CNT_W = $clog2(N + 1);
  localparam int C_CLR  = 10;
  localparam int C_ENT  = 11;
  localparam int C_BSP  = 12;
  localparam int C_NONE = 13;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             key_valid = 1'b0;
  logic [1:0]       key_col = 2'd0;
  logic [1:0]       key_row = 2'd0;
  logic             op_ack = 1'b0;
  logic [4*N-1:0]   bcd;
  logic [CNT_W-1:0] digit_cnt;
  logic [BIN_W-1:0] bin;
  logic             op_valid;
  logic             key_reject;

  int checks   = 0;
  int failures = 0;

  // Reference model: entered digits as a list, plus mode 0=entry 1=convert 2=done.
  int kmap [16];
  int q [$];
  int m_mode  = 0;
  int m_left  = 0;
  bit m_valid = 1'b0;
  int m_bin   = 0;
  bit m_prev  = 1'b0;
  bit m_rej   = 1'b0;

  keypad_operand_entry #(.NUM_DIGITS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid_i  (key_valid),
    .key_col_i    (key_col),
    .key_row_i    (key_row),
    .op_ack_i     (op_ack),
    .bcd_o        (bcd),
    .digit_cnt_o  (digit_cnt),
    .bin_o        (bin),
    .op_valid_o   (op_valid),
    .key_reject_o (key_reject)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int q_value();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction

  function automatic int q_bcd();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  // One clock: apply inputs, advance the model across the edge, compare outputs.
  task automatic step(input bit kv, input int pos, input bit ack);
    bit ev;
    int code;
    key_valid = kv;
    key_col   = 2'(pos >> 2);
    key_row   = 2'(pos & 3);
    op_ack    = ack;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      m_mode  = 0;
      m_valid = 1'b0;
      m_bin   = 0;
      m_prev  = 1'b0;
      m_rej   = 1'b0;
    end else begin
      ev     = kv && !m_prev;
      m_prev = kv;
      m_rej  = 1'b0;
      code   = kmap[pos];
      case (m_mode)
        0: begin
          if (ev) begin
            if (code <= 9) begin
              if (q.size() < N) q.push_back(code);
              else m_rej = 1'b1;
            end else if (code == C_CLR) begin
              q.delete();
            end else if (code == C_ENT) begin
              if (q.size() == 0) m_rej = 1'b1;
              else begin
                m_mode = 1;
                m_left = N;
              end
            end else if (code == C_BSP) begin
`ifdef KEYPAD_BACKSPACE_EN
              if (q.size() > 0) void'(q.pop_back());
              else m_rej = 1'b1;
`else
              m_rej = 1'b1;
`endif
            end else begin
              m_rej = 1'b1;
            end
          end
        end
        1: begin
          if (ev) m_rej = 1'b1;
          m_left--;
          if (m_left == 0) begin
            m_mode  = 2;
            m_valid = 1'b1;
            m_bin   = q_value();
          end
        end
        default: begin
          if (ev) m_rej = 1'b1;
          if (ack) begin
            m_valid = 1'b0;
            q.delete();
            m_mode = 0;
          end
        end
      endcase
    end
    check_eq("key_reject", 32'(key_reject), 32'(m_rej));
    check_eq("op_valid", 32'(op_valid), 32'(m_valid));
    check_eq("bcd", 32'(bcd), 32'(q_bcd()));
    check_eq("digit_cnt", 32'(digit_cnt), 32'(q.size()));
    if (m_mode != 1) check_eq("bin", 32'(bin), 32'(m_bin));
  endtask

  task automatic press(input int pos);
    step(1'b1, pos, 1'b0);
    step(1'b0, pos, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int pos_hold;
    int rej_seen;
    kmap = '{1, 4, 7, C_CLR, 2, 5, 8, 0, 3, 6, 9, C_ENT, C_NONE, C_NONE, C_NONE, C_BSP};
    pos_hold = 0;

    rst = 1'b0;
    step(1'b0, 0, 1'b0);
    check_eq("reset_bcd", 32'(bcd), 32'h0);
    check_eq("reset_valid", 32'(op_valid), 32'h0);
    rst = 1'b1;
    idle(2);

    // Plan 1: 4, 7, # -> 47 after two conversion cycles, then ack.
    press(1);
    press(2);
    check_eq("tp1_bcd", 32'(bcd), 32'h47);
    step(1'b1, 11, 1'b0);
    step(1'b0, 11, 1'b0);
    check_eq("tp1_valid_early", 32'(op_valid), 32'h0);
    step(1'b0, 0, 1'b0);
    check_eq("tp1_valid", 32'(op_valid), 32'h1);
    check_eq("tp1_bin", 32'(bin), 32'd47);
    idle(2);
    step(1'b0, 0, 1'b1);
    check_eq("tp1_ack_bcd", 32'(bcd), 32'h0);

    // Plan 2: 1, 2, 3 -> 12 and one reject.
    press(0);
    press(4);
    step(1'b1, 8, 1'b0);
    check_eq("tp2_reject", 32'(key_reject), 32'h1);
    step(1'b0, 8, 1'b0);
    check_eq("tp2_bcd", 32'(bcd), 32'h12);

    // Plan 3: clear, then # on an empty operand.
    press(3);
    press(5);
    press(3);
    check_eq("tp3_cnt", 32'(digit_cnt), 32'h0);
    press(11);
    idle(3);
    check_eq("tp3_valid", 32'(op_valid), 32'h0);

    // Plan 4: a held key yields one digit.
    rej_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 10, 1'b0);
      rej_seen += int'(key_reject);
    end
    step(1'b0, 10, 1'b0);
    check_eq("tp4_bcd", 32'(bcd), 32'h09);
    check_eq("tp4_rejects", 32'(rej_seen), 32'h0);

    // Plan 5: key with simultaneous ack in DONE, then reset mid-conversion.
    press(3);
    press(10);
    press(11);
    idle(2);
    step(1'b1, 8, 1'b1);
    check_eq("tp5_reject", 32'(key_reject), 32'h1);
    step(1'b0, 8, 1'b0);
    check_eq("tp5_bin", 32'(bin), 32'd9);
    press(10);
    step(1'b1, 11, 1'b0);
    do_reset();
    check_eq("tp5_rst_bin", 32'(bin), 32'h0);
    idle(1);

    // Plan 6: 9, 8, D.
    press(10);
    press(6);
    press(15);
`ifdef KEYPAD_BACKSPACE_EN
    check_eq("tp6_bcd", 32'(bcd), 32'h09);
`else
    check_eq("tp6_bcd", 32'(bcd), 32'h98);
`endif
    press(3);

    // Randomized traffic, biased toward ENT so conversions happen often.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        bit kv;
        if (key_valid) kv = ($urandom_range(0, 1) == 1);
        else begin
          kv = ($urandom_range(0, 1) == 1);
          if (kv) pos_hold = ($urandom_range(0, 3) == 0) ? 11 : int'($urandom_range(0, 15));
        end
        step(kv, pos_hold, ($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
Multi-digit decimal operand entry for the multiplier front end. Takes column/row codes from the 4x4 keypad scanner and maps them to key codes. Shifts digits into an N-digit BCD register, with clear, enter and optional backspace keys. On enter, converts the BCD value to binary sequentially and presents it to the multiplier datapath through a valid/ack handshake.

Parameters:
NUM_DIGITS, 2, maximum decimal digits per operand (1..4)
BIN_W, $clog2(10**NUM_DIGITS), width of the binary result (derived; not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
key_valid_i  in  1  level from scanner; high while a debounced key is held
key_col_i  in  2  column code of held key
key_row_i  in  2  row code of held key
op_ack_i  in  1  consumer accepts operand (sampled only in DONE)
bcd_o  out  4*NUM_DIGITS  entered digits; [3:0] = most recently entered digit
digit_cnt_o  out  $clog2(NUM_DIGITS+1)  number of digits entered
bin_o  out  BIN_W  binary value of the operand
op_valid_o  out  1  operand ready; held until ack
key_reject_o  out  1  one-cycle pulse when a key event is discarded

Behaviour:
- Reset (rst=0 at an edge): state ENTRY; bcd_o=0; digit_cnt_o=0; bin_o=0; op_valid_o=0; key_reject_o=0; edge-detect flop=0. A reset mid-conversion or while in DONE aborts the operand.
- Key event: an edge where key_valid_i=1 and the registered previous key_valid_i=0. A held key produces exactly one event. Col/row are sampled at that edge.
- Position pos={col,row}. Map:
  - 0→1, 1→4, 2→7, 4→2, 5→5, 6→8, 8→3, 9→6, 10→9, 7→0
  - 3→CLR (*), 11→ENT (#), 15→BSP (D)
  - 12, 13, 14→NONE (A/B/C)
- Key actions take effect at the event edge; outputs reflect them after that edge.
- ENTRY state:
  - Digit with cnt<NUM_DIGITS: bcd shifts left 4 bits, the new digit enters [3:0], cnt+1.
  - Digit with cnt=NUM_DIGITS: no change, reject pulse.
  - CLR: bcd=0, cnt=0 (no reject, even when already empty).
  - ENT with cnt=0: reject pulse, stay in ENTRY.
  - ENT with cnt>0: bin accumulator cleared, index reset, go to CONVERT.
  - NONE: reject pulse.
  - BSP: see Optional Feature.
- CONVERT: exactly NUM_DIGITS cycles. At each edge k=1..NUM_DIGITS, acc = acc*10 + digit[NUM_DIGITS-k] (MSD first; leading zeros contribute 0). At edge NUM_DIGITS, go to DONE and set op_valid_o=1. Latency from the ENT edge to visible op_valid_o is NUM_DIGITS cycles. bcd_o and cnt are held.
- DONE: op_valid_o=1; bin_o and bcd_o stable. An edge with op_ack_i=1 sets op_valid_o=0, bcd=0, cnt=0, and goes to ENTRY. bin_o keeps its last value until the next ENT.
- Key events in CONVERT or DONE are discarded with a reject pulse, including when simultaneous with ack (ack wins).
- op_ack_i is ignored outside DONE.
- Arithmetic: acc is BIN_W bits. The maximum 10^N-1 fits, so no overflow is possible.

Optional Feature:
KEYPAD_BACKSPACE_EN
- Defined: BSP in ENTRY with cnt>0 shifts bcd right 4 bits (zero fill at MSD) and decrements cnt. BSP with cnt=0 gives a reject pulse.
- Undefined: BSP is treated as NONE (reject pulse, no state change).
- In either build, BSP in CONVERT or DONE is rejected.

Decomposition:
- Shared package keypad_pkg holds:
  - key_code_t enum: KEY_0..KEY_9, KEY_CLR, KEY_ENT, KEY_BSP, KEY_NONE
  - entry_state_t enum: ENTRY, CONVERT, DONE
  - localparams for special positions: POS_CLR=3, POS_ENT=11, POS_BSP=15
- Sub-module keypad_key_map: combinational pos→key_code_t, reused by the single-digit decoder path.

Test Plan:
1. NUM_DIGITS=2; press pos1 (4), pos2 (7), pos11 (#) → bcd_o=0x47, cnt=2; op_valid_o rises 2 cycles after the # edge with bin_o=47; op_ack_i=1 → op_valid_o=0, bcd_o=0, ENTRY.
2. Press 1, 2, 3 → bcd_o=0x12, cnt=2; the third press gives one key_reject_o pulse.
3. Press 5, then pos3 (*) → bcd_o=0, cnt=0; then # → reject pulse, no op_valid_o.
4. key_valid_i held high 10 cycles at pos10 → exactly one digit (bcd_o=0x09), no reject.
5. Enter 9, #; press 3 while in DONE with simultaneous op_ack_i → reject pulse, ack honoured, bcd_o=0, bin_o stays 9; rst=0 during CONVERT → all outputs 0, ENTRY.
6. With KEYPAD_BACKSPACE_EN, press 9, 8, D → bcd_o=0x09, cnt=1. Without it, D → reject pulse, bcd_o=0x98.
